// File: rtl/core_pkg.sv
// Shared core types for the hazard controller: FSM states and register-number constants.
package core_pkg;

  typedef enum logic {RUN, MD_WAIT} state_e;

  localparam int REG_NUM_W = 5;
  localparam logic [REG_NUM_W-1:0] X0 = 5'd0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: pipeline hazard inputs and register enable/flush outputs.
// master = pipeline side, slave = hazard controller.
interface hazard_ctrl_if
  import core_pkg::*;
#(
  parameter int CNT_W = 32
);
  logic [REG_NUM_W-1:0] i_id_rs1_num;
  logic [REG_NUM_W-1:0] i_id_rs2_num;
  logic                 i_id_uses_rs1;
  logic                 i_id_uses_rs2;
  logic [REG_NUM_W-1:0] i_ex_rd_num;
  logic                 i_ex_is_load;
  logic                 i_ex_redirect;
  logic                 i_ex_md_start;
  logic                 i_mem_busy;
  logic                 o_pc_en;
  logic                 o_if_id_en;
  logic                 o_id_ex_en;
  logic                 o_ex_mem_en;
  logic                 o_if_id_flush;
  logic                 o_id_ex_flush;
  logic                 o_ex_mem_flush;
  logic [CNT_W-1:0]     o_stall_cycles;

  modport master (
    output i_id_rs1_num, i_id_rs2_num, i_id_uses_rs1, i_id_uses_rs2,
           i_ex_rd_num, i_ex_is_load, i_ex_redirect, i_ex_md_start, i_mem_busy,
    input  o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en,
           o_if_id_flush, o_id_ex_flush, o_ex_mem_flush, o_stall_cycles
  );

  modport slave (
    input  i_id_rs1_num, i_id_rs2_num, i_id_uses_rs1, i_id_uses_rs2,
           i_ex_rd_num, i_ex_is_load, i_ex_redirect, i_ex_md_start, i_mem_busy,
    output o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en,
           o_if_id_flush, o_id_ex_flush, o_ex_mem_flush, o_stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl_detect.sv
// Load-use comparator: flags an ID source that depends on a load still in EX.
// Pure combinational, zero latency.
module hazard_detect
  import core_pkg::*;
(
  input  logic [REG_NUM_W-1:0] rs1_num,
  input  logic [REG_NUM_W-1:0] rs2_num,
  input  logic                 uses_rs1,
  input  logic                 uses_rs2,
  input  logic [REG_NUM_W-1:0] rd_num,
  input  logic                 is_load,
  output logic                 load_use
);
  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = is_load && (rd_num != X0) &&
                    ((uses_rs1 && (rs1_num == rd_num)) ||
                     (uses_rs2 && (rs2_num == rd_num)));
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: PC/IF-ID/ID-EX/EX-MEM enables and flushes, zero-latency decisions.
// Define HAZARD_CTRL_MULDIV_EN to enable multi-cycle mul/div occupancy of EX (MD_WAIT state).
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int MD_CYCLES = 4,
  parameter int CNT_W     = 32
)(
  input  logic         i_clk,
  input  logic         i_rst_n,
  hazard_ctrl_if.slave bus
);
  logic             pc_en, if_id_en, id_ex_en, ex_mem_en;
  logic             if_id_flush, id_ex_flush, ex_mem_flush;
  logic             load_use;
  state_e           state_d, state_q;
  logic [CNT_W-1:0] stall_cycles_d, stall_cycles_q;

`ifdef HAZARD_CTRL_MULDIV_EN
  localparam int MD_CNT_W = (MD_CYCLES > 2) ? $clog2(MD_CYCLES) : 1;
  logic [MD_CNT_W-1:0] md_cnt_d, md_cnt_q;
`else
  logic        unused_md_start;
  logic [31:0] unused_md_cycles;
  assign unused_md_start  = bus.i_ex_md_start;
  assign unused_md_cycles = MD_CYCLES;
`endif

  hazard_detect u_detect (
    .rs1_num  (bus.i_id_rs1_num),
    .rs2_num  (bus.i_id_rs2_num),
    .uses_rs1 (bus.i_id_uses_rs1),
    .uses_rs2 (bus.i_id_uses_rs2),
    .rd_num   (bus.i_ex_rd_num),
    .is_load  (bus.i_ex_is_load),
    .load_use (load_use)
  );

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    state_d      = state_q;
`ifdef HAZARD_CTRL_MULDIV_EN
    md_cnt_d     = md_cnt_q;
`endif
    if (!i_rst_n) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en}  = 4'b0000;
      {if_id_flush, id_ex_flush, ex_mem_flush} = 3'b111;
    end else if (bus.i_mem_busy) begin
      // Freeze everything, including any pending redirect or mul/div progress.
      {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
`ifdef HAZARD_CTRL_MULDIV_EN
    end else if (state_q == MD_WAIT) begin
      if (md_cnt_q != '0) begin
        {pc_en, if_id_en, id_ex_en} = 3'b000;
        ex_mem_flush = 1'b1;
        md_cnt_d     = md_cnt_q - MD_CNT_W'(1);
      end else begin
        state_d = RUN;
      end
`endif
    end else if (bus.i_ex_redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
`ifdef HAZARD_CTRL_MULDIV_EN
    end else if (bus.i_ex_md_start) begin
      {pc_en, if_id_en, id_ex_en} = 3'b000;
      ex_mem_flush = 1'b1;
      state_d      = MD_WAIT;
      md_cnt_d     = MD_CNT_W'(MD_CYCLES - 2);
`endif
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end

    stall_cycles_d = stall_cycles_q;
    if (!pc_en && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q        <= RUN;
      stall_cycles_q <= '0;
`ifdef HAZARD_CTRL_MULDIV_EN
      md_cnt_q       <= '0;
`endif
    end else begin
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
`ifdef HAZARD_CTRL_MULDIV_EN
      md_cnt_q       <= md_cnt_d;
`endif
    end
  end

  assign bus.o_pc_en        = pc_en;
  assign bus.o_if_id_en     = if_id_en;
  assign bus.o_id_ex_en     = id_ex_en;
  assign bus.o_ex_mem_en    = ex_mem_en;
  assign bus.o_if_id_flush  = if_id_flush;
  assign bus.o_id_ex_flush  = id_ex_flush;
  assign bus.o_ex_mem_flush = ex_mem_flush;
  assign bus.o_stall_cycles = stall_cycles_q;
endmodule
